burst_master_port: RTL and testbench
====================================

// Module: burst_master_port
// PURPOSE
//  Next-generation serial-bus master port: accepts one request per handshake from a master device and runs a burst of
//  1..MAX_BURST words over a LANE_WIDTH-bit serial bus. Adds to single-word ports: multi-bit lanes, burst length,
//  bounded retry on missing slave ack, per-word handshakes and error reporting. Sits between master device and
//  arbiter/address decoder/serial bus.
// PARAMETERS
//  ADDR_WIDTH           16  device address width; upper ADDR_WIDTH-SLAVE_MEM_ADDR_WIDTH bits select slave
//  DATA_WIDTH           8   word width
//  SLAVE_MEM_ADDR_WIDTH 12  slave memory address width
//  LANE_WIDTH           1   serial bits per beat; must divide DATA_WIDTH, SLAVE_MEM_ADDR_WIDTH, slave-sel width, BURST_W
//  MAX_BURST            16  max words per burst; BURST_W = $clog2(MAX_BURST)
//  TIMEOUT_TIME         5   WAIT cycles before ack timeout
//  MAX_RETRY            2   re-requests after timeout before abort
// PORTS
//  clk     in  1           clock
//  rst     in  1           reset
//  dwdata  in  DATA_WIDTH  write word; must hold next word whenever dwack pulses
//  drdata  out DATA_WIDTH  read word, valid while drvalid=1
//  daddr   in  ADDR_WIDTH  start address
//  dlen    in  BURST_W     burst length minus 1
//  dmode   in  1           0 read, 1 write
//  dvalid  in  1           request valid
//  dready  out 1           1 in IDLE only
//  dwack   out 1           1-cycle pulse: current dwdata word latched
//  drvalid out 1           1-cycle pulse: drdata holds a complete read word
//  derr    out 1           1-cycle pulse: request aborted after retries
//  mrdata  in  LANE_WIDTH  serial read beat;   mwdata out LANE_WIDTH serial write/addr beat
//  mmode   out 1           latched dmode;      mvalid out 1 mwdata beat valid
//  svalid  in  1           mrdata beat valid;  ack    in  1 address decoder acknowledge
//  mbreq   out 1           bus request (state!=IDLE); mbgrant in 1 grant; msplit in 1 split
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset (incl. mid-burst) -> IDLE, counters/retries cleared.
//    All registered outputs are 0 except dready=1. No derr pulse is issued on reset.
//  - Serialization: all fields are sent LSB-first, LANE_WIDTH bits per beat.
//  - IDLE: when dvalid=1, latch daddr, dlen, dmode and dwdata; assert dwack for 1 cycle if dmode=1; go to REQ.
//    dvalid is ignored outside IDLE.
//  - REQ: wait for mbgrant -> SADDR.
//  - SADDR: mvalid=1 and shift the slave-select bits; after the last beat -> WAIT with the timeout counter cleared.
//  - WAIT: mvalid=0 and the timeout counter increments. If ack=1 -> ADDR (ack wins over a timeout in the same cycle).
//    If timeout==TIMEOUT_TIME with no ack: when retries<MAX_RETRY, increment retries and go to REQ (mbreq stays 1);
//    otherwise pulse derr and go to IDLE.
//  - ADDR: shift the memory address, then the BURST_W-bit dlen field, with mvalid=1. Then go to WDATA (mode=1) or RDATA.
//  - WDATA: shift the latched word with mvalid=1. On the last beat of a word, if words remain: pulse dwack and load
//    dwdata into the shift register, so the next word follows with no bubble. After word dlen -> IDLE.
//  - RDATA: mvalid=0. Each cycle with svalid=1 captures one mrdata beat. On a completed word, update drdata and
//    pulse drvalid in the next cycle. After word dlen -> IDLE.
//  - SPLIT: in RDATA, msplit=1 -> SPLIT. msplit wins over svalid in the same cycle; that beat is dropped and the
//    slave must resend it. SPLIT keeps the word/beat counters and holds mvalid=0. When !msplit && mbgrant -> RDATA.
//  - Beat counter wraps at DATA_WIDTH/LANE_WIDTH; word counter stops at dlen. There are no illegal states:
//    default -> IDLE.
// TESTING
//  1 LANE=1, write daddr=16'h3005, dlen=0, dwdata=8'hA5, grant at once, ack on the 2nd WAIT cycle
//    -> 4 select beats (0011 LSB-first), 12 address beats, 4 length beats, 8 data beats 1,0,1,0,0,1,0,1; then dready=1.
//  2 LANE=2, read dlen=3, slave returns 8'h11,22,33,44
//    -> 4 drvalid pulses with drdata 11,22,33,44; dready=1 after the last pulse.
//  3 No ack ever, MAX_RETRY=2 -> 3 SADDR passes, a single derr pulse, then IDLE; mbreq stays high until the abort.
//  4 msplit asserted mid-word during a read, together with svalid -> that beat is dropped. After the split clears and
//    the grant returns, the resent beats complete the correct word.
//  5 rst=1 during WDATA of a 4-word burst -> next cycle all outputs are 0 and dready=1.
//    A new request then completes normally.
//  6 ack and timeout in the same cycle -> ADDR is entered, no retry, and no derr.

Source files
------------

// File: rtl/burst_master_port.sv
// burst_master_port
//   Master-side port of a multi-lane serial bus. Takes one request per
//   handshake from the master device and runs a burst of 1..MAX_BURST words.
//   Each request sends the slave-select field. It then waits for the address
//   decoder ack, with a bounded number of re-requests. Next it sends the
//   memory address and the burst length. Last comes the data phase: it
//   serialises write words or collects read words. Every field goes LSB-first,
//   LANE_WIDTH bits per beat.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   dwdata/dwack      write word from master; dwack pulses when a word is latched
//   drdata/drvalid    read word to master; drvalid pulses when drdata is fresh
//   daddr/dlen/dmode  start address, burst length-1, 0=read 1=write
//   dvalid/dready     request handshake (dready high only in IDLE)
//   derr              pulse when a request is aborted after all retries
//   mrdata/svalid     serial read beat from slave and its valid
//   mwdata/mvalid     serial select/address/write beat and its valid
//   mmode             latched transfer mode
//   ack               address decoder acknowledge
//   mbreq/mbgrant     bus request / grant
//   msplit            slave split during a read
module burst_master_port #(
  parameter  int ADDR_WIDTH           = 16,
  parameter  int DATA_WIDTH           = 8,
  parameter  int SLAVE_MEM_ADDR_WIDTH = 12,
  parameter  int LANE_WIDTH           = 1,
  parameter  int MAX_BURST            = 16,
  parameter  int TIMEOUT_TIME         = 5,
  parameter  int MAX_RETRY            = 2,
  localparam int BURST_W              = $clog2(MAX_BURST)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] dwdata,
  output logic [DATA_WIDTH-1:0] drdata,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [BURST_W-1:0]    dlen,
  input  logic                  dmode,
  input  logic                  dvalid,
  output logic                  dready,
  output logic                  dwack,
  output logic                  drvalid,
  output logic                  derr,
  input  logic [LANE_WIDTH-1:0] mrdata,
  output logic [LANE_WIDTH-1:0] mwdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  svalid,
  input  logic                  ack,
  output logic                  mbreq,
  input  logic                  mbgrant,
  input  logic                  msplit
);

  localparam int SEL_W      = ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH;
  localparam int AL_W       = SLAVE_MEM_ADDR_WIDTH + BURST_W;
  localparam int SH_A       = (AL_W > DATA_WIDTH) ? AL_W : DATA_WIDTH;
  localparam int SH_W       = (SEL_W > SH_A) ? SEL_W : SH_A;
  localparam int SEL_BEATS  = SEL_W / LANE_WIDTH;
  localparam int AL_BEATS   = AL_W / LANE_WIDTH;
  localparam int DATA_BEATS = DATA_WIDTH / LANE_WIDTH;
  localparam int BEAT_W     = $clog2(SH_W / LANE_WIDTH + 1);
  localparam int TO_W       = $clog2(TIMEOUT_TIME + 1);
  localparam int RT_W       = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SADDR, S_WAIT, S_ADDR, S_WDATA, S_RDATA, S_SPLIT
  } state_t;

  state_t                  state;
  logic [SH_W-1:0]         shreg;
  logic [BEAT_W-1:0]       beat;
  logic [BURST_W-1:0]      wcnt;
  logic [BURST_W-1:0]      len_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   word_q;
  logic [DATA_WIDTH-1:0]   rsr;
  logic [TO_W-1:0]         tcnt;
  logic [RT_W-1:0]         retry;

  // The outgoing beat is always the low lane of the shift register.
  assign mwdata = shreg[LANE_WIDTH-1:0];

  // Read words arrive LSB-first: new lanes enter at the top and move down.
  function automatic logic [DATA_WIDTH-1:0] rd_shift(input logic [DATA_WIDTH-1:0] cur,
                                                     input logic [LANE_WIDTH-1:0] lane);
    return (cur >> LANE_WIDTH) | (DATA_WIDTH'(lane) << (DATA_WIDTH - LANE_WIDTH));
  endfunction

  // Address fields are taken from addr_q, not shifted in place. A retry can
  // then resend the slave-select field unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      shreg   <= '0;
      beat    <= '0;
      wcnt    <= '0;
      tcnt    <= '0;
      retry   <= '0;
      drdata  <= '0;
      dready  <= 1'b1;
      dwack   <= 1'b0;
      drvalid <= 1'b0;
      derr    <= 1'b0;
      mmode   <= 1'b0;
      mvalid  <= 1'b0;
      mbreq   <= 1'b0;
    end else begin
      dwack   <= 1'b0;
      drvalid <= 1'b0;
      derr    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dvalid) begin
            addr_q <= daddr;
            len_q  <= dlen;
            word_q <= dwdata;
            mmode  <= dmode;
            dwack  <= dmode;
            retry  <= '0;
            dready <= 1'b0;
            mbreq  <= 1'b1;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (mbgrant) begin
            shreg  <= SH_W'(addr_q[ADDR_WIDTH-1 -: SEL_W]);
            beat   <= '0;
            mvalid <= 1'b1;
            state  <= S_SADDR;
          end
        end
        S_SADDR: begin
          if (beat == BEAT_W'(SEL_BEATS - 1)) begin
            mvalid <= 1'b0;
            tcnt   <= '0;
            state  <= S_WAIT;
          end else begin
            shreg <= shreg >> LANE_WIDTH;
            beat  <= beat + BEAT_W'(1);
          end
        end
        S_WAIT: begin
          tcnt <= tcnt + TO_W'(1);
          // ack is checked first, so an ack in the last WAIT cycle still wins.
          if (ack) begin
            shreg  <= SH_W'({len_q, addr_q[SLAVE_MEM_ADDR_WIDTH-1:0]});
            beat   <= '0;
            mvalid <= 1'b1;
            state  <= S_ADDR;
          end else if (tcnt == TO_W'(TIMEOUT_TIME - 1)) begin
            if (retry < RT_W'(MAX_RETRY)) begin
              retry <= retry + RT_W'(1);
              state <= S_REQ;
            end else begin
              derr   <= 1'b1;
              dready <= 1'b1;
              mbreq  <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        S_ADDR: begin
          if (beat == BEAT_W'(AL_BEATS - 1)) begin
            beat <= '0;
            wcnt <= '0;
            if (mmode) begin
              shreg <= SH_W'(word_q);
              state <= S_WDATA;
            end else begin
              mvalid <= 1'b0;
              state  <= S_RDATA;
            end
          end else begin
            shreg <= shreg >> LANE_WIDTH;
            beat  <= beat + BEAT_W'(1);
          end
        end
        S_WDATA: begin
          if (beat == BEAT_W'(DATA_BEATS - 1)) begin
            beat <= '0;
            if (wcnt == len_q) begin
              mvalid <= 1'b0;
              dready <= 1'b1;
              mbreq  <= 1'b0;
              state  <= S_IDLE;
            end else begin
              // Load the next word on the last beat so the stream has no gap.
              wcnt  <= wcnt + BURST_W'(1);
              shreg <= SH_W'(dwdata);
              dwack <= 1'b1;
            end
          end else begin
            shreg <= shreg >> LANE_WIDTH;
            beat  <= beat + BEAT_W'(1);
          end
        end
        S_RDATA: begin
          // A split drops the beat offered in the same cycle. The slave resends it.
          if (msplit) begin
            state <= S_SPLIT;
          end else if (svalid) begin
            rsr <= rd_shift(rsr, mrdata);
            if (beat == BEAT_W'(DATA_BEATS - 1)) begin
              beat    <= '0;
              drdata  <= rd_shift(rsr, mrdata);
              drvalid <= 1'b1;
              if (wcnt == len_q) begin
                dready <= 1'b1;
                mbreq  <= 1'b0;
                state  <= S_IDLE;
              end else begin
                wcnt <= wcnt + BURST_W'(1);
              end
            end else begin
              beat <= beat + BEAT_W'(1);
            end
          end
        end
        S_SPLIT: begin
          if (!msplit && mbgrant) state <= S_RDATA;
        end
        default: begin
          mvalid <= 1'b0;
          dready <= 1'b1;
          mbreq  <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_master_port.sv
// Bench for burst_master_port. One instance has one-bit lanes (u1) and one
// has two-bit lanes (u2). They share the request and bus inputs, and a select
// picks which instance the transaction driver observes.
module tb_burst_master_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, dvalid, dmode, svalid, ack, mbgrant, msplit;
  logic [7:0] dwdata;
  logic [15:0] daddr;
  logic [3:0] dlen;
  logic [1:0] lane;
  logic       mrdata1;
  logic [1:0] mrdata2;
  assign mrdata1 = lane[0];
  assign mrdata2 = lane;

  logic [7:0] drdata1, drdata2;
  logic       dready1, dwack1, drvalid1, derr1, mmode1, mvalid1, mbreq1, mwdata1;
  logic       dready2, dwack2, drvalid2, derr2, mmode2, mvalid2, mbreq2;
  logic [1:0] mwdata2;

  burst_master_port u1 (
    .clk(clk), .rst(rst), .dwdata(dwdata), .drdata(drdata1), .daddr(daddr), .dlen(dlen),
    .dmode(dmode), .dvalid(dvalid), .dready(dready1), .dwack(dwack1), .drvalid(drvalid1),
    .derr(derr1), .mrdata(mrdata1), .mwdata(mwdata1), .mmode(mmode1), .mvalid(mvalid1),
    .svalid(svalid), .ack(ack), .mbreq(mbreq1), .mbgrant(mbgrant), .msplit(msplit));

  burst_master_port #(.LANE_WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .dwdata(dwdata), .drdata(drdata2), .daddr(daddr), .dlen(dlen),
    .dmode(dmode), .dvalid(dvalid), .dready(dready2), .dwack(dwack2), .drvalid(drvalid2),
    .derr(derr2), .mrdata(mrdata2), .mwdata(mwdata2), .mmode(mmode2), .mvalid(mvalid2),
    .svalid(svalid), .ack(ack), .mbreq(mbreq2), .mbgrant(mbgrant), .msplit(msplit));

  logic       sel;
  logic [7:0] o_drdata;
  logic [1:0] o_mwdata;
  logic       o_dready, o_dwack, o_drvalid, o_derr, o_mvalid, o_mbreq, o_mmode;
  always_comb begin
    o_drdata  = sel ? drdata2  : drdata1;
    o_mwdata  = sel ? mwdata2  : {1'b0, mwdata1};
    o_dready  = sel ? dready2  : dready1;
    o_dwack   = sel ? dwack2   : dwack1;
    o_drvalid = sel ? drvalid2 : drvalid1;
    o_derr    = sel ? derr2    : derr1;
    o_mvalid  = sel ? mvalid2  : mvalid1;
    o_mbreq   = sel ? mbreq2   : mbreq1;
    o_mmode   = sel ? mmode2   : mmode1;
  end

  typedef struct {
    logic            inst;
    logic            mode;
    logic [15:0]     addr;
    logic [3:0]      len;
    logic [3:0][7:0] w;
    int              ack_at;
    int              split_at;
    logic [63:0]     exp_beats;
    int              exp_nb;
    int              exp_dwack;
    int              exp_derr;
    int              exp_nsaddr;
    int              exp_ndr;
  } row_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    else pass_cnt++;
  endtask

  function automatic row_t mk(input logic inst, input logic mode, input logic [15:0] addr,
                              input logic [3:0] len, input logic [31:0] words, input int ack_at,
                              input int split_at, input logic [63:0] eb, input int enb,
                              input int edw, input int ederr, input int ensaddr, input int endr);
    row_t r;
    r.inst = inst; r.mode = mode; r.addr = addr; r.len = len; r.w = words;
    r.ack_at = ack_at; r.split_at = split_at; r.exp_beats = eb; r.exp_nb = enb;
    r.exp_dwack = edw; r.exp_derr = ederr; r.exp_nsaddr = ensaddr; r.exp_ndr = endr;
    return r;
  endfunction

  function automatic logic [1:0] bv(input row_t r, input int idx, input int dbeats, input int lw);
    logic [7:0] wd;
    wd = r.w[idx / dbeats];
    return 2'(wd >> (lw * (idx % dbeats))) & ((lw == 2) ? 2'b11 : 2'b01);
  endfunction

  task automatic do_reset();
    rst = 1'b1; dvalid = 1'b0; svalid = 1'b0; ack = 1'b0; msplit = 1'b0; mbgrant = 1'b0;
    lane = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one request from IDLE to completion and compares what came out.
  task automatic check_row(input row_t r, input int id);
    int selb, dbeats, lw, total_rb, nb, run, nbursts, nsaddr, ndw, nderr, ndr, mlow, wi, wc, rbeat, sp;
    logic [63:0] beats;
    logic [7:0]  rd [4];
    logic        in_wait, in_read, done, mm;
    logic [1:0]  lmask;
    sel = r.inst;
    selb = r.inst ? 2 : 4; dbeats = r.inst ? 4 : 8; lw = r.inst ? 2 : 1;
    lmask = r.inst ? 2'b11 : 2'b01;
    total_rb = (int'(r.len) + 1) * dbeats;
    nb = 0; run = 0; nbursts = 0; nsaddr = 0; ndw = 0; nderr = 0; ndr = 0; mlow = 0;
    wi = 0; wc = 0; rbeat = 0; sp = (r.split_at >= 0) ? 0 : 4;
    beats = '0; in_wait = 1'b0; in_read = 1'b0; done = 1'b0; mm = 1'b0;
    for (int k = 0; k < 4; k++) rd[k] = '0;
    daddr = r.addr; dlen = r.len; dmode = r.mode; dwdata = r.w[0];
    mbgrant = 1'b1; ack = 1'b0; msplit = 1'b0; svalid = 1'b0; lane = 2'b00;
    dvalid = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
    mm = o_mmode;
    for (int c = 0; c < 400 && !done; c++) begin
      if (o_mvalid) begin
        if (nb * lw < 63) beats = beats | (64'(o_mwdata & lmask) << (nb * lw));
        nb++; run++;
        in_wait = 1'b0;
      end else begin
        if (run > 0) begin
          nbursts++;
          if (run == selb) begin nsaddr++; in_wait = 1'b1; wc = 0; end
          else if (!r.mode) in_read = 1'b1;
        end
        run = 0;
      end
      if (o_dwack) begin ndw++; wi++; if (wi < 4) dwdata = r.w[wi]; end
      if (o_derr) nderr++;
      if (o_drvalid) begin if (ndr < 4) rd[ndr] = o_drdata; ndr++; end
      if (!o_mbreq && !o_dready) mlow++;
      if (o_dready) done = 1'b1;
      if (in_wait) begin wc++; ack = (wc == r.ack_at); end
      else ack = 1'b0;
      svalid = 1'b0;
      if (in_read) begin
        case (sp)
          1: begin msplit = 1'b1; sp = 2; end
          2: begin msplit = 1'b0; sp = 3; end
          3: begin mbgrant = 1'b1; sp = 4; end
          default: begin
            if (rbeat < total_rb) begin
              svalid = 1'b1;
              lane = bv(r, rbeat, dbeats, lw);
              if (sp == 0 && rbeat == r.split_at) begin
                msplit = 1'b1; mbgrant = 1'b0; sp = 1;
              end else begin
                rbeat++;
              end
            end
          end
        endcase
      end
      if (!done) @(negedge clk);
    end
    svalid = 1'b0; msplit = 1'b0; ack = 1'b0;
    chk($sformatf("row%0d done", id), 64'(done), 64'd1);
    chk($sformatf("row%0d mmode", id), 64'(mm), 64'(r.mode));
    chk($sformatf("row%0d nbeats", id), 64'(nb), 64'(r.exp_nb));
    chk($sformatf("row%0d beats", id), beats, r.exp_beats);
    chk($sformatf("row%0d saddr_passes", id), 64'(nsaddr), 64'(r.exp_nsaddr));
    chk($sformatf("row%0d bursts", id), 64'(nbursts), 64'(r.exp_nsaddr + ((r.exp_derr != 0) ? 0 : 1)));
    chk($sformatf("row%0d dwack", id), 64'(ndw), 64'(r.exp_dwack));
    chk($sformatf("row%0d derr", id), 64'(nderr), 64'(r.exp_derr));
    chk($sformatf("row%0d mbreq_drop", id), 64'(mlow), 64'd0);
    chk($sformatf("row%0d mbreq_end", id), 64'(o_mbreq), 64'd0);
    chk($sformatf("row%0d drvalid", id), 64'(ndr), 64'(r.exp_ndr));
    for (int k = 0; k < r.exp_ndr && k < 4; k++)
      chk($sformatf("row%0d drdata%0d", id, k), 64'(rd[k]), 64'(r.w[k]));
  endtask

  row_t rows [8];

  initial begin
    int cnt;
    rst = 1'b1; dvalid = 1'b0; dmode = 1'b0; svalid = 1'b0; ack = 1'b0; mbgrant = 1'b0;
    msplit = 1'b0; dwdata = '0; daddr = '0; dlen = '0; lane = 2'b00; sel = 1'b0;

    //           inst mode addr      len words          ack split beats             nb dwk err sad ndr
    rows[0] = mk(0, 1, 16'h3005, 0, 32'h000000A5, 2, -1, 64'hA500053,    28, 1, 0, 1, 0);
    rows[1] = mk(0, 1, 16'hF123, 0, 32'h0000003C, 1, -1, 64'h3C0123F,    28, 1, 0, 1, 0);
    rows[2] = mk(0, 1, 16'h0FFF, 0, 32'h00000000, 3, -1, 64'h000FFF0,    28, 1, 0, 1, 0);
    rows[3] = mk(0, 1, 16'h8001, 1, 32'h0000C35A, 1, -1, 64'hC35A10018,  36, 2, 0, 1, 0);
    rows[4] = mk(0, 1, 16'h7ABC, 0, 32'h00000096, 5, -1, 64'h960ABC7,    28, 1, 0, 1, 0);
    rows[5] = mk(0, 1, 16'h3005, 0, 32'h000000A5, 0, -1, 64'h333,        12, 1, 1, 3, 0);
    rows[6] = mk(1, 0, 16'hA123, 3, 32'h44332211, 1, -1, 64'h3123A,      10, 0, 0, 1, 4);
    rows[7] = mk(1, 0, 16'h4C08, 1, 32'h0000E75C, 2,  5, 64'h1C084,      10, 0, 0, 1, 2);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset dready1", 64'(dready1), 64'd1);
    chk("reset dready2", 64'(dready2), 64'd1);
    chk("reset outs1", 64'({mbreq1, mvalid1, mwdata1, dwack1, drvalid1, derr1, mmode1, drdata1}), 64'd0);
    chk("reset outs2", 64'({mbreq2, mvalid2, mwdata2, dwack2, drvalid2, derr2, mmode2, drdata2}), 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      check_row(rows[i], i);
    end

    // Reset in the middle of a 4-word write burst, then a clean request.
    do_reset();
    sel = 1'b0;
    daddr = 16'h1234; dlen = 4'd3; dmode = 1'b1; dwdata = 8'h11; mbgrant = 1'b1; ack = 1'b1;
    dvalid = 1'b1;
    @(negedge clk);
    dvalid = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 23; c++) begin
      if (mvalid1) cnt++;
      if (cnt < 23) @(negedge clk);
    end
    chk("t5 reached wdata", 64'(cnt), 64'd23);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ack = 1'b0;
    chk("t5 dready", 64'(dready1), 64'd1);
    chk("t5 mbreq", 64'(mbreq1), 64'd0);
    chk("t5 mvalid", 64'(mvalid1), 64'd0);
    chk("t5 mwdata", 64'(mwdata1), 64'd0);
    chk("t5 pulses", 64'({dwack1, drvalid1, derr1}), 64'd0);
    chk("t5 mmode", 64'(mmode1), 64'd0);
    chk("t5 drdata", 64'(drdata1), 64'd0);
    check_row(mk(0, 1, 16'h2345, 0, 32'h00000077, 1, -1, 64'h7703452, 28, 1, 0, 1, 0), 8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
